// File: rtl/router_fsm_ctrl.sv
// Packet sequencer for the 1x3 router: steers each packet through decode, load, full-stall and
// parity phases, and flushes output FIFOs whose reader has gone quiet for too long.
module router_fsm_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    input  logic       low_pkt_valid,
    input  logic       parity_done,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic [2:0] write_enb,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       soft_reset_q, soft_reset_d;

    logic hdr_valid;
    logic hdr_empty;
    logic full_sel;
    logic sr_sel;
    logic empty_sel;

    assign hdr_valid  = pkt_valid && (data_in != 2'd3);
    assign vld_out    = ~fifo_empty;
    assign soft_reset = soft_reset_q;

    // Port-indexed selects; index 3 never names a FIFO, so it reads as inactive.
    always_comb begin
        hdr_empty = 1'b0;
        full_sel  = 1'b0;
        sr_sel    = 1'b0;
        empty_sel = 1'b0;
        if (data_in != 2'd3) begin
            hdr_empty = fifo_empty[data_in];
        end
        if (addr_q != 2'd3) begin
            full_sel  = fifo_full[addr_q];
            sr_sel    = soft_reset_q[addr_q];
            empty_sel = fifo_empty[addr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_valid) begin
                    addr_d  = data_in;
                    state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (full_sel)        state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!full_sel) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = full_sel ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (empty_sel) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A flushed destination abandons the packet wherever it is.
        if (sr_sel && state_q != DECODE_ADDRESS) begin
            state_d = DECODE_ADDRESS;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        busy          = 1'b0;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        rst_int_reg   = 1'b0;
        write_enb_reg = 1'b0;
        case (state_q)
            DECODE_ADDRESS:     detect_add = 1'b1;
            LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
            LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
            FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
            LOAD_AFTER_FULL:    begin laf_state = 1'b1; busy = 1'b1; write_enb_reg = 1'b1; end
            LOAD_PARITY:        begin busy = 1'b1; write_enb_reg = 1'b1; end
            CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
            WAIT_TILL_EMPTY:    busy = 1'b1;
            default:            detect_add = 1'b0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            write_enb[i] = write_enb_reg && (addr_q == 2'(i));
        end
    end

    // A port stalls while it holds data nobody is reading; the counter wraps as it fires.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]        = '0;
            soft_reset_d[i] = 1'b0;
            if (vld_out[i] && !read_enb[i]) begin
                if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_reset_q <= soft_reset_d;
        end
    end

endmodule
